// File: rtl/wide_cmp_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : wide_cmp_sequencer
//  Purpose  : Multi-cycle unsigned magnitude comparator for NBYTES*8-bit
//             operands. A single cascadable 8-bit compare slice is reused
//             every cycle, walking the operands MSB byte first and carrying
//             the running EQ/GT between cycles.
//  Ports    : clk     - rising-edge clock
//             rst_n   - asynchronous active-low reset
//             start   - request, sampled only in IDLE
//             a_in    - operand A, captured on accepted start
//             b_in    - operand B, captured on accepted start
//             busy    - high while the byte walk is running
//             done    - one-cycle pulse when EQ/GT/cycles become valid
//             EQ      - A == B, held until the next result
//             GT      - A >  B, held until the next result
//             cycles  - number of slices evaluated for the last result
//  Options  : CMP_EARLY_EXIT_EN - when defined, the walk stops at the first
//             differing byte; otherwise all NBYTES slices are always evaluated.
//  Revision : 1.0 - initial release
// ============================================================================
module wide_cmp_sequencer #(
    parameter int NBYTES = 4
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            start,
    input  logic [8*NBYTES-1:0]             a_in,
    input  logic [8*NBYTES-1:0]             b_in,
    output logic                            busy,
    output logic                            done,
    output logic                            EQ,
    output logic                            GT,
    output logic [$clog2(NBYTES):0]         cycles
);

    localparam int W    = 8 * NBYTES;
    localparam int IDXW = $clog2(NBYTES);
    localparam int CW   = IDXW + 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_FIN  = 2'd2;

    localparam logic [IDXW-1:0] c_IDX_TOP = IDXW'(NBYTES - 1);

    logic [1:0]      state_q,  state_d;
    logic [W-1:0]    a_q,      a_d;
    logic [W-1:0]    b_q,      b_d;
    logic [IDXW-1:0] idx_q,    idx_d;
    logic [CW-1:0]   cnt_q,    cnt_d;
    logic            eq_acc_q, eq_acc_d;
    logic            gt_acc_q, gt_acc_d;
    logic            eq_res_q, eq_res_d;
    logic            gt_res_q, gt_res_d;
    logic [CW-1:0]   cyc_q,    cyc_d;

    // Byte selection by shifting keeps the index arithmetic width-clean.
    logic [W-1:0] w_a_sh;
    logic [W-1:0] w_b_sh;
    logic [7:0]   w_a_byte;
    logic [7:0]   w_b_byte;
    logic         w_slice_eq;
    logic         w_slice_gt;
    logic         w_last;

    assign w_a_sh   = a_q >> {idx_q, 3'b000};
    assign w_b_sh   = b_q >> {idx_q, 3'b000};
    assign w_a_byte = w_a_sh[7:0];
    assign w_b_byte = w_b_sh[7:0];

    // Cascadable 8-bit slice: a higher byte that already differs dominates.
    assign w_slice_eq = eq_acc_q & (w_a_byte == w_b_byte);
    assign w_slice_gt = gt_acc_q | (eq_acc_q & (w_a_byte > w_b_byte));

`ifdef CMP_EARLY_EXIT_EN
    // Once EQ drops, the remaining lower bytes cannot change the outcome.
    assign w_last = (idx_q == '0) | ~w_slice_eq;
`else
    assign w_last = (idx_q == '0);
`endif

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        eq_acc_d = eq_acc_q;
        gt_acc_d = gt_acc_q;
        eq_res_d = eq_res_q;
        gt_res_d = gt_res_q;
        cyc_d    = cyc_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_d      = a_in;
                    b_d      = b_in;
                    idx_d    = c_IDX_TOP;
                    cnt_d    = '0;
                    eq_acc_d = 1'b1;
                    gt_acc_d = 1'b0;
                    state_d  = S_RUN;
                end
            end
            S_RUN: begin
                eq_acc_d = w_slice_eq;
                gt_acc_d = w_slice_gt;
                cnt_d    = cnt_q + 1'b1;
                if (w_last) begin
                    // Results are loaded on the edge entering FIN so that they
                    // are already valid during the cycle done is high. idx is
                    // left untouched here, so it never wraps below zero.
                    eq_res_d = w_slice_eq;
                    gt_res_d = w_slice_gt;
                    cyc_d    = cnt_q + 1'b1;
                    state_d  = S_FIN;
                end else begin
                    idx_d = idx_q - 1'b1;
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            idx_q    <= '0;
            cnt_q    <= '0;
            eq_acc_q <= 1'b1;
            gt_acc_q <= 1'b0;
            eq_res_q <= 1'b1;
            gt_res_q <= 1'b0;
            cyc_q    <= '0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
            eq_acc_q <= eq_acc_d;
            gt_acc_q <= gt_acc_d;
            eq_res_q <= eq_res_d;
            gt_res_q <= gt_res_d;
            cyc_q    <= cyc_d;
        end
    end

    assign busy   = (state_q == S_RUN);
    assign done   = (state_q == S_FIN);
    assign EQ     = eq_res_q;
    assign GT     = gt_res_q;
    assign cycles = cyc_q;

endmodule
`default_nettype wire

// File: tb/tb_wide_cmp_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_wide_cmp_sequencer
//  Purpose  : Self-checking bench for wide_cmp_sequencer (NBYTES=4). Stimulus
//             pushes hand-computed expectations into a scoreboard queue; a
//             monitor pops and compares on every done pulse.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_wide_cmp_sequencer;

    localparam int NB = 4;

`ifdef CMP_EARLY_EXIT_EN
    localparam bit c_EARLY = 1'b1;
`else
    localparam bit c_EARLY = 1'b0;
`endif

    logic        clk    = 1'b0;
    logic        rst_n  = 1'b0;
    logic        start  = 1'b0;
    logic [31:0] a_in   = '0;
    logic [31:0] b_in   = '0;
    wire         busy;
    wire         done;
    wire         EQ;
    wire         GT;
    wire  [2:0]  cycles;

    wide_cmp_sequencer #(.NBYTES(NB)) u_dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .a_in   (a_in),
        .b_in   (b_in),
        .busy   (busy),
        .done   (done),
        .EQ     (EQ),
        .GT     (GT),
        .cycles (cycles)
    );

    always #60 clk = ~clk;

    typedef struct {
        logic       eq;
        logic       gt;
        logic [2:0] cyc;
        int         edge_no;
    } exp_t;

    exp_t sb[$];
    int   total    = 0;
    int   bad      = 0;
    int   edge_cnt = 0;

    always @(posedge clk) edge_cnt++;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, edge_cnt);
        end
    endtask

    // k = 1-based position of the first differing byte from the MSB
    // (NB when operands are equal or only the LSB differs).
    task automatic push_exp(input logic eq, input logic gt, input int k, input int s_edge);
        exp_t e;
        int   cyc;
        cyc       = c_EARLY ? k : NB;
        e.eq      = eq;
        e.gt      = gt;
        e.cyc     = 3'(cyc);
        e.edge_no = s_edge + cyc;   // start edge counts as the 1st of cyc+1
        sb.push_back(e);
    endtask

    // Monitor
    always @(negedge clk) begin : mon
        exp_t e;
        if (done) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL spurious_done: got done=1 expected no pending result (edge %0d)", edge_cnt);
            end else begin
                e = sb.pop_front();
                chk("EQ",        int'(EQ),     int'(e.eq));
                chk("GT",        int'(GT),     int'(e.gt));
                chk("cycles",    int'(cycles), int'(e.cyc));
                chk("done_edge", edge_cnt,     e.edge_no);
            end
        end
    end

    task automatic issue(input logic [31:0] a, input logic [31:0] b,
                         input logic eq, input logic gt, input int k);
        @(negedge clk);
        a_in  = a;
        b_in  = b;
        start = 1'b1;
        push_exp(eq, gt, k, edge_cnt + 1);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (done) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!seen) begin
            total++;
            bad++;
            $display("FAIL done_timeout: got no done expected done within 20 cycles");
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_busy"},   int'(busy),   0);
        chk({tag, "_done"},   int'(done),   0);
        chk({tag, "_EQ"},     int'(EQ),     1);
        chk({tag, "_GT"},     int'(GT),     0);
        chk({tag, "_cycles"}, int'(cycles), 0);
    endtask

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        eq;
        logic        gt;
        int          k;
    } vec_t;

    vec_t vecs[6] = '{
        '{32'h0000_0000, 32'h0000_0000, 1'b1, 1'b0, 4},
        '{32'h0000_0001, 32'h0000_0000, 1'b0, 1'b1, 4},
        '{32'h7F00_0000, 32'h8000_00FF, 1'b0, 1'b0, 1},
        '{32'h1234_5678, 32'h1235_5678, 1'b0, 1'b0, 2},
        '{32'hFFFF_FFFF, 32'hFFFF_00FF, 1'b0, 1'b1, 3},
        '{32'hA5A5_A5A5, 32'hA5A5_A5A5, 1'b1, 1'b0, 4}
    };

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        bit seen;
        // Reset state
        repeat (3) @(negedge clk);
        chk_reset_vals("reset");
        rst_n = 1'b1;

        // Directed vectors
        foreach (vecs[i]) begin
            issue(vecs[i].a, vecs[i].b, vecs[i].eq, vecs[i].gt, vecs[i].k);
            wait_done();
        end

        // Previous result (A5.. equal) must hold during a following RUN
        issue(32'h1234_5678, 32'h1234_5600, 1'b0, 1'b1, 4);
        chk("hold_busy",   int'(busy),   1);
        chk("hold_EQ",     int'(EQ),     1);
        chk("hold_GT",     int'(GT),     0);
        chk("hold_cycles", int'(cycles), 4);
        wait_done();

        // start pulsed while busy with other operands must be ignored
        issue(32'h1234_5678, 32'h1234_5678, 1'b1, 1'b0, 4);
        a_in  = 32'hFFFF_FFFF;
        b_in  = 32'h0000_0000;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done();
        repeat (8) @(negedge clk);

        // Back-to-back: start held through FIN is taken in the next IDLE cycle
        @(negedge clk);
        a_in  = 32'hFFFF_FFFF;
        b_in  = 32'hFFFF_00FF;
        start = 1'b1;
        push_exp(1'b0, 1'b1, 3, edge_cnt + 1);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) begin
            total++;
            bad++;
            $display("FAIL b2b_timeout: got no done expected done within 20 cycles");
        end
        a_in = 32'h0000_0000;
        b_in = 32'h0000_0001;
        push_exp(1'b0, 1'b0, 4, edge_cnt + 2);
        @(negedge clk);
        @(negedge clk);
        start = 1'b0;
        wait_done();
        repeat (2) @(negedge clk);

        // Reset mid-RUN: aborts with reset values and no done
        issue(32'h0000_0001, 32'h0000_0000, 1'b0, 1'b1, 4);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        void'(sb.pop_back());
        chk_reset_vals("abort");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        issue(32'h8000_0000, 32'h7FFF_FFFF, 1'b0, 1'b1, 1);
        wait_done();

        repeat (6) @(negedge clk);
        chk("sb_empty", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
